pulse_train_gen: RTL

//   Programmable square-wave / pulse-train source, the stimulus-side counterpart of the

---
 rtl/pulse_train_gen.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_train_gen.sv
// Programmable square-wave / pulse-train source with a registered rise strobe.
// Optional burst mode (fixed pulse count, then wait for enable to drop): define PULSE_GEN_BURST_EN.
module pulse_train_gen #(
    parameter int PERIOD_W = 16,
    parameter int BURST_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [PERIOD_W-1:0] half_period,
    input  logic [BURST_W-1:0]  burst_len,
    output logic                signal_out,
    output logic                edge_strobe,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_STOP     = 2'd2;
`ifdef PULSE_GEN_BURST_EN
    localparam logic [1:0] S_WAIT_LOW = 2'd3;
    localparam logic [BURST_W-1:0] B_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
`endif
    localparam logic [PERIOD_W-1:0] P_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [1:0]          state;
    logic [PERIOD_W-1:0] counter;
    logic [PERIOD_W-1:0] hp_active;
    logic [PERIOD_W-1:0] hp_shadow;
    logic [PERIOD_W-1:0] hp_eff;
    logic [PERIOD_W-1:0] hp_next;
    logic [PERIOD_W-1:0] hp_last;
    logic                terminal;
    logic                burst_last;

    assign hp_eff   = (half_period == '0) ? P_ONE : half_period;
    assign hp_last  = hp_active - P_ONE;
    assign terminal = (counter == hp_last);
    // Value hp_active must hold whenever we settle back into IDLE, so a load
    // landing in the same cycle is not lost.
    assign hp_next  = load ? hp_eff : hp_shadow;
    assign busy     = (state == S_RUN) || (state == S_STOP);

`ifdef PULSE_GEN_BURST_EN
    logic [BURST_W-1:0] burst_shadow;
    logic [BURST_W-1:0] burst_active;
    logic [BURST_W-1:0] edge_cnt;
    logic               rise_now;

    assign rise_now   = (state == S_RUN) && enable && !signal_out && terminal;
    assign burst_last = (burst_active != '0) && (edge_cnt == burst_active);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_shadow <= '0;
            burst_active <= '0;
            edge_cnt     <= '0;
        end else begin
            if (load)
                burst_shadow <= burst_len;
            if (state == S_IDLE && enable) begin
                burst_active <= load ? burst_len : burst_shadow;
                edge_cnt     <= B_ONE;
            end else if (rise_now) begin
                edge_cnt <= edge_cnt + B_ONE;
            end
        end
    end
`else
    logic burst_len_unused;
    assign burst_len_unused = ^burst_len;
    assign burst_last       = 1'b0;
    assign done             = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            signal_out  <= 1'b0;
            edge_strobe <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
            done        <= 1'b0;
`endif
            counter     <= '0;
            hp_active   <= P_ONE;
            hp_shadow   <= P_ONE;
        end else begin
            edge_strobe <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
            done        <= 1'b0;
`endif
            if (load)
                hp_shadow <= hp_eff;

            case (state)
                S_IDLE: begin
                    signal_out <= 1'b0;
                    counter    <= '0;
                    if (load)
                        hp_active <= hp_eff;
                    if (enable) begin
                        state       <= S_RUN;
                        signal_out  <= 1'b1;
                        edge_strobe <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (!enable && !signal_out) begin
                        // Low phase is simply abandoned; no rise can follow.
                        state     <= S_IDLE;
                        counter   <= '0;
                        hp_active <= hp_next;
                    end else if (terminal) begin
                        counter    <= '0;
                        hp_active  <= hp_shadow;
                        signal_out <= ~signal_out;
                        if (signal_out) begin
`ifdef PULSE_GEN_BURST_EN
                            if (burst_last) begin
                                done  <= 1'b1;
                                state <= S_WAIT_LOW;
                            end else
`endif
                            if (!enable)
                                state <= S_STOP;
                        end else begin
                            edge_strobe <= 1'b1;
                        end
                    end else begin
                        counter <= counter + P_ONE;
                        if (!enable)
                            state <= S_STOP;
                    end
                end

                S_STOP: begin
                    // Finish the high phase, then one full low phase, then IDLE.
                    if (terminal) begin
                        counter <= '0;
                        if (signal_out) begin
                            signal_out <= 1'b0;
                            hp_active  <= hp_shadow;
`ifdef PULSE_GEN_BURST_EN
                            if (burst_last) begin
                                done  <= 1'b1;
                                state <= S_WAIT_LOW;
                            end
`endif
                        end else begin
                            state     <= S_IDLE;
                            hp_active <= hp_next;
                        end
                    end else begin
                        counter <= counter + P_ONE;
                    end
                end

`ifdef PULSE_GEN_BURST_EN
                S_WAIT_LOW: begin
                    signal_out <= 1'b0;
                    counter    <= '0;
                    if (load)
                        hp_active <= hp_eff;
                    if (!enable)
                        state <= S_IDLE;
                end
`endif

                default: begin
                    state      <= S_IDLE;
                    signal_out <= 1'b0;
                    counter    <= '0;
                end
            endcase
        end
    end

endmodule
